clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 169 ++++++++++++++++
 tb/tb_clk_div_monitor.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock sampled on clkIn, locks after
// LOCK_COUNT consecutive good measurements and raises a sticky error on mismatch or stuck input.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int LOCK_COUNT = 4,
  parameter int HIGH_TOL   = 1
) (
  input  logic             clkIn,
  input  logic             reset,
  input  logic             enable,
  input  logic             divIn,
  input  logic [CNT_W-1:0] expPeriod,
  input  logic [CNT_W-1:0] expHigh,
  input  logic             clrErr,
  output logic [CNT_W-1:0] measPeriod,
  output logic [CNT_W-1:0] measHigh,
  output logic             measValid,
  output logic             locked,
  output logic             error
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam int               GW      = $clog2(LOCK_COUNT + 1);
  localparam logic [GW-1:0]    LOCK_TGT = GW'(LOCK_COUNT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_EDGE,
    S_TRACK,
    S_LOCKED,
    S_ERROR
  } state_t;

  state_t           r_state;
  logic             r_div_q;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_high_cnt;
  logic             r_high_done;
  logic [GW-1:0]    r_good_cnt;
  logic [CNT_W-1:0] r_meas_period;
  logic [CNT_W-1:0] r_meas_high;
  logic             r_meas_valid;
  logic             r_locked;
  logic             r_error;

  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_high_val;
  logic [CNT_W-1:0] w_high_abs;
  logic             w_cfg_ok;
  logic             w_good;
  logic             w_per_sat;
  logic [GW-1:0]    w_good_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign w_rise     = divIn & ~r_div_q;
  assign w_fall     = ~divIn & r_div_q;
  // A period without a falling edge reports the whole period as high time.
  assign w_high_val = r_high_done ? r_high_cnt : r_per_cnt;
  assign w_high_abs = (w_high_val >= expHigh) ? (w_high_val - expHigh) : (expHigh - w_high_val);
  assign w_cfg_ok   = (expPeriod != '0) && (expHigh < expPeriod);
  assign w_good     = w_cfg_ok && (r_per_cnt == expPeriod) && (w_high_abs <= CNT_W'(HIGH_TOL));
  assign w_per_sat  = (r_per_cnt == CNT_MAX);
  assign w_good_nxt = r_good_cnt + 1'b1;

  always_ff @(posedge clkIn or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_div_q       <= 1'b0;
      r_per_cnt     <= '0;
      r_high_cnt    <= '0;
      r_high_done   <= 1'b0;
      r_good_cnt    <= '0;
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_meas_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_div_q      <= divIn;
      r_meas_valid <= 1'b0;
      if (clrErr) r_error <= 1'b0;

      if (!enable) begin
        r_state     <= S_IDLE;
        r_per_cnt   <= '0;
        r_high_cnt  <= '0;
        r_high_done <= 1'b0;
        r_good_cnt  <= '0;
        r_locked    <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_WAIT_EDGE;

          S_WAIT_EDGE: begin
            if (w_rise) begin
              r_state     <= S_TRACK;
              r_per_cnt   <= CNT_W'(1);
              r_high_cnt  <= CNT_W'(1);
              r_high_done <= 1'b0;
            end
          end

          S_TRACK, S_LOCKED: begin
            if (w_rise) begin
              r_meas_period <= r_per_cnt;
              r_meas_high   <= w_high_val;
              r_meas_valid  <= 1'b1;
              r_per_cnt     <= CNT_W'(1);
              r_high_cnt    <= CNT_W'(1);
              r_high_done   <= 1'b0;
              if (w_good) begin
                if (r_state == S_TRACK) begin
                  r_good_cnt <= w_good_nxt;
                  if (w_good_nxt == LOCK_TGT) begin
                    r_state  <= S_LOCKED;
                    r_locked <= 1'b1;
                  end
                end
              end else if (r_state == S_TRACK) begin
                r_good_cnt <= '0;
              end else begin
                r_state    <= S_ERROR;
                r_locked   <= 1'b0;
                r_good_cnt <= '0;
                r_error    <= ~clrErr;
              end
            end else if (w_per_sat) begin
              // divIn stuck: no edge within the full counter range.
              r_state    <= S_ERROR;
              r_locked   <= 1'b0;
              r_good_cnt <= '0;
              r_error    <= ~clrErr;
            end else begin
              r_per_cnt <= sat_inc(r_per_cnt);
              if (!r_high_done) begin
                if (w_fall) r_high_done <= 1'b1;
                else        r_high_cnt  <= sat_inc(r_high_cnt);
              end
            end
          end

          S_ERROR: begin
            if (clrErr) begin
              r_state     <= S_WAIT_EDGE;
              r_error     <= 1'b0;
              r_per_cnt   <= '0;
              r_high_cnt  <= '0;
              r_high_done <= 1'b0;
              r_good_cnt  <= '0;
            end
          end

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign measPeriod = r_meas_period;
  assign measHigh   = r_meas_high;
  assign measValid  = r_meas_valid;
  assign locked     = r_locked;
  assign error      = r_error;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: expected measurements are queued per scenario
// and matched against every measValid pulse.
module tb_clk_div_monitor;

  logic       clkIn = 1'b0;
  logic       reset;
  logic       enable = 1'b0;
  logic       divIn = 1'b0;
  logic       clrErr = 1'b0;
  logic [7:0] expPeriod = 8'd4;
  logic [7:0] expHigh = 8'd2;
  logic [7:0] measPeriod;
  logic [7:0] measHigh;
  logic       measValid;
  logic       locked;
  logic       error;

  typedef struct {
    int per;
    int hi;
    bit lk;
    bit er;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  clk_div_monitor #(.CNT_W(8), .LOCK_COUNT(4), .HIGH_TOL(1)) dut (
    .clkIn(clkIn), .reset(reset), .enable(enable), .divIn(divIn),
    .expPeriod(expPeriod), .expHigh(expHigh), .clrErr(clrErr),
    .measPeriod(measPeriod), .measHigh(measHigh), .measValid(measValid),
    .locked(locked), .error(error)
  );

  always #5 clkIn = ~clkIn;

  // Scoreboard consumer: every measValid must match the oldest queued expectation.
  always @(negedge clkIn) begin
    exp_t e;
    if (measValid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_measValid got per=%0d hi=%0d, required no pulse", measPeriod, measHigh);
      end else begin
        e = sb.pop_front();
        if (measPeriod !== 8'(e.per)) begin
          errors++;
          $display("FAIL sb_period got %0d required %0d", measPeriod, e.per);
        end
        checks++;
        if (measHigh !== 8'(e.hi)) begin
          errors++;
          $display("FAIL sb_high got %0d required %0d", measHigh, e.hi);
        end
        checks++;
        if (locked !== e.lk) begin
          errors++;
          $display("FAIL sb_locked got %0b required %0b", locked, e.lk);
        end
        checks++;
        if (error !== e.er) begin
          errors++;
          $display("FAIL sb_error got %0b required %0b", error, e.er);
        end
      end
    end
  end

  task automatic push_exp(input int p, input int h, input bit lk, input bit er);
    sb.push_back('{p, h, lk, er});
  endtask

  task automatic drive_period(input int p, input int h);
    for (int i = 0; i < p; i++) begin
      divIn = (i < h);
      @(negedge clkIn);
    end
  endtask

  task automatic start_mon(input int ep, input int eh);
    expPeriod = 8'(ep);
    expHigh   = 8'(eh);
    divIn     = 1'b0;
    enable    = 1'b1;
    repeat (3) @(negedge clkIn);
  endtask

  task automatic stop_mon();
    divIn  = 1'b0;
    enable = 1'b0;
    clrErr = 1'b1;
    @(negedge clkIn);
    clrErr = 1'b0;
    @(negedge clkIn);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clkIn);
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      divIn = ~divIn;
      @(negedge clkIn);
      checks++;
      if ({measPeriod, measHigh, measValid, locked, error} !== 19'd0) begin
        errors++;
        $display("FAIL reset_outputs got %h required 0", {measPeriod, measHigh, measValid, locked, error});
      end
    end
    divIn  = 1'b0;
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clkIn);
  endtask

  task automatic test_div4();
    start_mon(4, 2);
    for (int k = 0; k < 5; k++) push_exp(4, 2, k >= 3, 1'b0);
    repeat (6) drive_period(4, 2);
    checks++;
    if (locked !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL div4_lock got locked=%0b error=%0b required 1/0", locked, error);
    end
    enable = 1'b0;
    @(negedge clkIn);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL disable_unlock got %0b required 0", locked);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div4_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_div5();
    start_mon(5, 2);
    for (int k = 0; k < 4; k++) push_exp(5, 3, k >= 3, 1'b0);
    repeat (5) drive_period(5, 3);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL div5_lock got %0b required 1", locked);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div5_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_bad_in_track();
    int pl[9] = '{4, 4, 4, 5, 4, 4, 4, 4, 4};
    int streak = 0;
    start_mon(4, 2);
    for (int k = 0; k < 8; k++) begin
      streak = (pl[k] == 4) ? streak + 1 : 0;
      push_exp(pl[k], 2, streak >= 4, 1'b0);
    end
    for (int k = 0; k < 9; k++) drive_period(pl[k], 2);
    checks++;
    if (locked !== 1'b1 || error !== 1'b0) begin
      errors++;
      $display("FAIL track_relock got locked=%0b error=%0b required 1/0", locked, error);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL track_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_cfg_invalid();
    start_mon(4, 4);
    for (int k = 0; k < 5; k++) push_exp(4, 2, 1'b0, 1'b0);
    repeat (6) drive_period(4, 2);
    checks++;
    if (locked !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL cfg_invalid got locked=%0b error=%0b required 0/0", locked, error);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL cfg_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_div6_switch();
    start_mon(4, 2);
    for (int k = 0; k < 4; k++) push_exp(4, 2, k >= 3, 1'b0);
    push_exp(4, 2, 1'b1, 1'b0);
    push_exp(6, 3, 1'b0, 1'b1);
    repeat (5) drive_period(4, 2);
    repeat (2) drive_period(6, 3);
    checks++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL div6_error got error=%0b locked=%0b required 1/0", error, locked);
    end
    clrErr = 1'b1;
    @(negedge clkIn);
    clrErr = 1'b0;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL div6_clr got %0b required 0", error);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL div6_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_stuck();
    int n = 0;
    start_mon(4, 2);
    for (int k = 0; k < 5; k++) push_exp(4, 2, k >= 3, 1'b0);
    repeat (6) drive_period(4, 2);
    divIn = 1'b0;
    while (error !== 1'b1 && n < 400) begin
      @(negedge clkIn);
      n++;
    end
    checks++;
    if (error !== 1'b1 || locked !== 1'b0) begin
      errors++;
      $display("FAIL stuck_error got error=%0b locked=%0b required 1/0", error, locked);
    end
    checks++;
    if (n != 252) begin
      errors++;
      $display("FAIL stuck_latency got %0d cycles required 252", n);
    end
    clrErr = 1'b1;
    @(negedge clkIn);
    clrErr = 1'b0;
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL stuck_clr got %0b required 0", error);
    end
    for (int k = 0; k < 4; k++) push_exp(4, 2, k >= 3, 1'b0);
    repeat (5) drive_period(4, 2);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL stuck_relock got %0b required 1", locked);
    end
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL stuck_drain got %0d pending required 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    start_mon(4, 2);
    for (int k = 0; k < 5; k++) push_exp(4, 2, k >= 3, 1'b0);
    repeat (5) drive_period(4, 2);
    divIn = 1'b1;
    @(negedge clkIn);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({measPeriod, measHigh, measValid, locked, error} !== 19'd0) begin
      errors++;
      $display("FAIL async_reset got %h required 0", {measPeriod, measHigh, measValid, locked, error});
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending got %0d required 0", sb.size());
    end
    @(negedge clkIn);
    divIn = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clkIn);
    push_exp(4, 2, 1'b0, 1'b0);
    push_exp(4, 2, 1'b0, 1'b0);
    repeat (3) drive_period(4, 2);
    stop_mon();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL midreset_drain got %0d pending required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_div4();
    test_div5();
    test_bad_in_track();
    test_cfg_invalid();
    test_div6_switch();
    test_stuck();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout got no completion required completion");
    $fatal(1, "watchdog");
  end

endmodule
